// File: rtl/acm_uart_bridge.sv
// UART <-> muacm stream bridge: 8N1 transmitter, receiver with byte FIFO,
// and an idle-line flush request generator for partial USB packets.
module acm_uart_bridge #(
    parameter int DIV        = 416,
    parameter int IDLE_FLUSH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] in_data,
    output logic       in_last,
    output logic       in_valid,
    input  logic       in_ready,
    output logic       in_flush_now,
    output logic       in_flush_time,
    input  logic [7:0] out_data,
    input  logic       out_last,
    input  logic       out_valid,
    output logic       out_ready,
    output logic       rx_overflow,
    output logic       rx_frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
    localparam logic [7:0]  IFL_M1  = 8'(IDLE_FLUSH - 1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // TX state
    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;

    // RX state
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    state_e      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_done, rx_good, rx_fall, rx_start;

    // FIFO state
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        push, pop, full;
    logic        ovf_q, ovf_d, ferr_q, ferr_d;

    // Idle flush state
    logic        armed_q, armed_d, expired_q, expired_d;
    logic        flush_q, flush_d;
    logic [15:0] idle_div_q, idle_div_d;
    logic [7:0]  idle_bits_q, idle_bits_d;

    logic unused_out_last;
    assign unused_out_last = out_last;

    assign uart_tx       = tx_q;
    assign out_ready     = (tx_state_q == S_IDLE) && !rst;
    assign in_valid      = (cnt_q != '0);
    assign in_data       = mem_q[rd_ptr_q];
    assign in_last       = 1'b0;
    assign in_flush_time = 1'b1;
    assign in_flush_now  = flush_q;
    assign rx_overflow   = ovf_q;
    assign rx_frame_err  = ferr_q;

    // TX next state: shift out start, 8 data bits LSB first, stop
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (out_valid) begin
                    tx_shift_d = out_data;
                    tx_d       = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign rx_fall  = rx_s3_q & ~rx_s2_q;
    assign rx_start = (rx_state_q == S_IDLE) && rx_fall;

    // RX next state: mid-bit sampling from the detected start edge
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        rx_good    = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else rx_bit_d = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_done    = 1'b1;
                    rx_good    = rx_s2_q;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // FIFO control; a pop frees the slot a same-cycle push needs
    always_comb begin
        full     = (cnt_q == CNT_FULL);
        pop      = in_valid && in_ready;
        push     = rx_done && rx_good && (!full || pop);
        ovf_d    = rx_done && rx_good && full && !pop;
        ferr_d   = rx_done && !rx_good;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) cnt_d = cnt_q + (AW + 1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (AW + 1)'(1);
    end

    // Idle timer: arm on push, count bit-times in RX idle, flush when empty
    always_comb begin
        armed_d     = armed_q;
        expired_d   = expired_q;
        idle_div_d  = idle_div_q;
        idle_bits_d = idle_bits_q;
        flush_d     = 1'b0;
        if (push) begin
            armed_d     = 1'b1;
            expired_d   = 1'b0;
            idle_div_d  = '0;
            idle_bits_d = '0;
        end else begin
            if (armed_q && !expired_q) begin
                if (rx_start) begin
                    armed_d = 1'b0;
                end else if (rx_state_q == S_IDLE) begin
                    if (idle_div_q == DIV_M1) begin
                        idle_div_d = '0;
                        if (idle_bits_q == IFL_M1) expired_d = 1'b1;
                        else idle_bits_d = idle_bits_q + 8'd1;
                    end else begin
                        idle_div_d = idle_div_q + 16'd1;
                    end
                end
            end
            if (armed_q && expired_q && cnt_q == '0) begin
                flush_d   = 1'b1;
                armed_d   = 1'b0;
                expired_d = 1'b0;
            end
        end
    end

    // State registers for both paths, FIFO pointers and pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            ferr_q      <= 1'b0;
            armed_q     <= 1'b0;
            expired_q   <= 1'b0;
            flush_q     <= 1'b0;
            idle_div_q  <= '0;
            idle_bits_q <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_s1_q     <= uart_rx;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            ferr_q      <= ferr_d;
            armed_q     <= armed_d;
            expired_q   <= expired_d;
            flush_q     <= flush_d;
            idle_div_q  <= idle_div_d;
            idle_bits_q <= idle_bits_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_shift_q;
    end

endmodule

// File: tb/tb_acm_uart_bridge.sv
// Directed bench for acm_uart_bridge with DIV=4, IDLE_FLUSH=2, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_acm_uart_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [7:0] in_data;
    logic       in_last, in_valid;
    logic       in_ready = 1'b0;
    logic       in_flush_now, in_flush_time;
    logic [7:0] out_data = 8'h00;
    logic       out_last = 1'b0;
    logic       out_valid = 1'b0;
    logic       out_ready, rx_overflow, rx_frame_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] popq[$];
    int n_valid, n_flush, n_ovf, n_ferr;
    int cyc = 0;
    int pop_cyc, flush_cyc;

    acm_uart_bridge #(.DIV(4), .IDLE_FLUSH(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .in_flush_now(in_flush_now),
        .in_flush_time(in_flush_time), .out_data(out_data),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    // Event monitor on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (in_valid && in_ready) begin
            popq.push_back(in_data);
            pop_cyc = cyc;
        end
        if (in_valid) n_valid++;
        if (in_flush_now) begin
            n_flush++;
            flush_cyc = cyc;
        end
        if (rx_overflow) n_ovf++;
        if (rx_frame_err) n_ferr++;
    end

    task automatic clear_mon();
        @(posedge clk);
        popq.delete();
        n_valid = 0;
        n_flush = 0;
        n_ovf = 0;
        n_ferr = 0;
        @(negedge clk);
    endtask

    // Drive one 8N1 frame on uart_rx, 4 cycles per bit; call at a negedge
    task automatic send_frame(input logic [7:0] b, input logic stopv);
        logic [9:0] f;
        f = {stopv, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({uart_tx, out_ready, in_valid, in_flush_now, rx_overflow,
             rx_frame_err} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=100000",
                     {uart_tx, out_ready, in_valid, in_flush_now,
                      rx_overflow, rx_frame_err});
        end
        checks++;
        if ({in_last, in_flush_time} !== 2'b01) begin
            failures++;
            $display("FAIL const_outputs got=%b want=01",
                     {in_last, in_flush_time});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b want=1", out_ready);
        end
    endtask

    task automatic test_tx();
        logic [39:0] cap, expv;
        logic [9:0] f;
        int lowcnt;
        f = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) expv[i] = f[i / 4];
        lowcnt = 0;
        out_data = 8'hA5;
        out_valid = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cap[i] = uart_tx;
            if (out_ready === 1'b0) lowcnt++;
            @(negedge clk);
        end
        checks++;
        if (cap !== expv) begin
            failures++;
            $display("FAIL tx_wave_a5 got=%h want=%h", cap, expv);
        end
        checks++;
        if (lowcnt != 40) begin
            failures++;
            $display("FAIL tx_ready_low got=%0d want=40", lowcnt);
        end
        checks++;
        if ({out_ready, uart_tx} !== 2'b11) begin
            failures++;
            $display("FAIL tx_back_idle got=%b want=11", {out_ready, uart_tx});
        end
    endtask

    task automatic test_rx();
        int d;
        in_ready = 1'b1;
        clear_mon();
        send_frame(8'h3C, 1'b1);
        repeat (30) @(negedge clk);
        checks++;
        if (popq.size() != 1 || n_valid != 1) begin
            failures++;
            $display("FAIL rx_single pops=%0d valid_cycles=%0d want=1/1",
                     popq.size(), n_valid);
        end else begin
            checks++;
            if (popq[0] !== 8'h3C) begin
                failures++;
                $display("FAIL rx_data got=%h want=3c", popq[0]);
            end
        end
        checks++;
        if (n_flush != 1) begin
            failures++;
            $display("FAIL rx_flush_count got=%0d want=1", n_flush);
        end else begin
            d = flush_cyc - pop_cyc;
            checks++;
            if (d < 7 || d > 11) begin
                failures++;
                $display("FAIL rx_flush_delay got=%0d want=7..11", d);
            end
        end
    endtask

    task automatic test_overflow();
        in_ready = 1'b0;
        clear_mon();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        repeat (20) @(negedge clk);
        send_frame(8'h05, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (n_ovf != 1) begin
            failures++;
            $display("FAIL ovf_count got=%0d want=1", n_ovf);
        end
        checks++;
        if (in_valid !== 1'b1 || in_data !== 8'h01) begin
            failures++;
            $display("FAIL ovf_head got=%b/%h want=1/01", in_valid, in_data);
        end
        checks++;
        if (n_flush != 0) begin
            failures++;
            $display("FAIL flush_while_full got=%0d want=0", n_flush);
        end
        in_ready = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (popq.size() != 4) begin
            failures++;
            $display("FAIL drain_count got=%0d want=4", popq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (popq[i] !== 8'(i + 1)) begin
                    failures++;
                    $display("FAIL drain_order idx=%0d got=%h want=%h",
                             i, popq[i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (n_flush != 1) begin
            failures++;
            $display("FAIL deferred_flush got=%0d want=1", n_flush);
        end
    endtask

    task automatic test_frame_err();
        in_ready = 1'b1;
        clear_mon();
        send_frame(8'h55, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (n_ferr != 1 || n_valid != 0) begin
            failures++;
            $display("FAIL frame_err ferr=%0d valid=%0d want=1/0",
                     n_ferr, n_valid);
        end
        clear_mon();
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (n_ferr != 0 || n_valid != 0 || n_ovf != 0) begin
            failures++;
            $display("FAIL glitch ferr=%0d valid=%0d ovf=%0d want=0/0/0",
                     n_ferr, n_valid, n_ovf);
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] cap, expv;
        logic [9:0] f;
        in_ready = 1'b0;
        clear_mon();
        send_frame(8'h77, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (in_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_fifo got=%b want=1", in_valid);
        end
        out_data = 8'h3C;
        out_valid = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 2) uart_rx = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (uart_tx !== 1'b0) begin
            failures++;
            $display("FAIL mid_tx_low got=%b want=0", uart_tx);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({uart_tx, out_ready, in_valid} !== 3'b100) begin
            failures++;
            $display("FAIL mid_reset got=%b want=100",
                     {uart_tx, out_ready, in_valid});
        end
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        in_ready = 1'b1;
        clear_mon();
        f = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 40; i++) expv[i] = f[i / 4];
        out_data = 8'h5A;
        out_valid = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cap[i] = uart_tx;
            @(negedge clk);
        end
        checks++;
        if (cap !== expv) begin
            failures++;
            $display("FAIL post_reset_tx got=%h want=%h", cap, expv);
        end
        send_frame(8'hC3, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (popq.size() != 1 || n_ferr != 0) begin
            failures++;
            $display("FAIL post_reset_rx pops=%0d ferr=%0d want=1/0",
                     popq.size(), n_ferr);
        end else begin
            checks++;
            if (popq[0] !== 8'hC3) begin
                failures++;
                $display("FAIL post_reset_rx_data got=%h want=c3", popq[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_overflow();
        test_frame_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
